// File: rtl/uart_loader_pkg.sv
// Shared types and widths for the UART program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_loader_pkg;

  // Data-path width shared with the core's memory port B.
  localparam int DATA_W = 32;

  // Width of the committed-word counter (covers MAX_WORDS up to 32767).
  localparam int WC_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Load bus from the UART loader to the core's memory port B.
// Latency: n/a (wires only).
// Backpressure: none; the core writes every cycle while uart_finish is low.
interface uart_loader_if;
  import uart_loader_pkg::*;

  logic [DATA_W-1:0] uart_data;
  logic [DATA_W-1:0] uart_addr;
  logic              uart_finish;
  logic [WC_W-1:0]   word_count;
  logic              frame_err;

  modport master (
    output uart_data, uart_addr, uart_finish, word_count, frame_err
  );

  modport slave (
    input uart_data, uart_addr, uart_finish, word_count, frame_err
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start/data/stop FSM, mid-bit sampling.
// Latency: byte_valid ~CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the start edge.
// Backpressure: none; hold freezes the FSM and suppresses both output pulses.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       hold,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic           rx_s1, rx_s2, rx_d;
  uart_rx_state_t state, state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           fall, tick_half, tick_full, restart;

  assign fall      = rx_d & ~rx_s2;
  assign tick_half = (baud_cnt == HALF_LAST);
  assign tick_full = (baud_cnt == FULL_LAST);
  // The baud counter restarts at every sample point so each phase times from zero.
  assign restart   = (state == IDLE) | ((state == START) ? tick_half : tick_full);
  assign byte_out  = shift;

  // Synchronize rx; the third stage only feeds falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // State register, frozen once loading has finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else if (!hold) state <= state_nxt;
  end

  // Next-state: half-bit check rejects start glitches, then 8 data bits and a stop bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (tick_half) state_nxt = rx_s2 ? IDLE : DATA;
      DATA:    if (tick_full && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (tick_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: one-cycle pulse at the stop-bit sample, good or bad framing.
  always_comb begin
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    if (state == STOP && tick_full && !hold) begin
      byte_valid      = rx_s2;
      frame_err_pulse = ~rx_s2;
    end
  end

  // Baud counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (!hold) begin
      baud_cnt <= restart ? '0 : baud_cnt + CNT_W'(1);
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && tick_full) begin
        shift   <= {rx_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Packs UART bytes little-endian into 32-bit words and hands them to memory port B.
// Latency: word commits 1 cycle after its 4th byte; uart_finish 1 cycle after a finish cause.
// Backpressure: none; after finish the receiver and packer freeze until reset.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 100,
  parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0,
  parameter int                MAX_WORDS    = 16384,
  parameter int                IDLE_TIMEOUT = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          skip,
  uart_loader_if.master bus
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   WC_MAX    = WC_W'(MAX_WORDS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT);

  logic [7:0]        byte_out;
  logic              byte_valid, frame_err_pulse;
  logic [1:0]        byte_idx;
  logic [23:0]       pack;
  logic [DATA_W-1:0] data_q, addr_q;
  logic [WC_W-1:0]   wc_q;
  logic              finish_q, ferr_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept, commit, finish_cond, loading;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .hold           (finish_q),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .frame_err_pulse(frame_err_pulse)
  );

  assign accept      = byte_valid & ~finish_q & (wc_q != WC_MAX);
  assign commit      = accept & (byte_idx == 2'd3);
  // The idle timer only runs once a transfer has actually begun.
  assign loading     = (wc_q != '0) | (byte_idx != 2'd0);
  assign finish_cond = skip | (wc_q == WC_MAX) | (idle_cnt == IDLE_LAST);

  // Packer: first three bytes park in pack, the fourth commits the whole word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      pack     <= '0;
      data_q   <= '0;
      addr_q   <= BASE_ADDR;
      wc_q     <= '0;
    end else if (accept) begin
      if (commit) begin
        data_q   <= {byte_out, pack};
        addr_q   <= BASE_ADDR + DATA_W'({wc_q, 2'b00});
        wc_q     <= wc_q + WC_W'(1);
        byte_idx <= '0;
      end else begin
        case (byte_idx)
          2'd0:    pack[7:0]   <= byte_out;
          2'd1:    pack[15:8]  <= byte_out;
          default: pack[23:16] <= byte_out;
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Idle timer: cleared by each good byte, saturates at the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (!finish_q) begin
      if (byte_valid) idle_cnt <= '0;
      else if (loading && idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Sticky status flags: finish from any cause, framing error from any bad stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (finish_cond) finish_q <= 1'b1;
      if (frame_err_pulse) ferr_q <= 1'b1;
    end
  end

  assign bus.uart_data   = data_q;
  assign bus.uart_addr   = addr_q;
  assign bus.uart_finish = finish_q;
  assign bus.word_count  = wc_q;
  assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed UART bytes in, expected commits queued.
// Latency: commits are checked whenever word_count advances.
// Backpressure: n/a.
module tb_uart_loader;

  localparam int CPB = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rx   = 1'b1;
  logic skip = 1'b0;

  always #5 clk = ~clk;

  uart_loader_if bus();

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (32'h0),
    .MAX_WORDS   (3),
    .IDLE_TIMEOUT(200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .skip(skip),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [14:0] wc;
    bit          fin_next;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] a, input int wc, input bit fin);
    exp_t e;
    e.data     = d;
    e.addr     = a;
    e.wc       = 15'(wc);
    e.fin_next = fin;
    exp_q.push_back(e);
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    rx   = 1'b1;
    skip = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"},   bus.uart_data, 32'h0);
    check({tag, "_addr"},   bus.uart_addr, 32'h0);
    check({tag, "_finish"}, {31'd0, bus.uart_finish}, 32'd0);
    check({tag, "_count"},  {17'd0, bus.word_count}, 32'd0);
    check({tag, "_ferr"},   {31'd0, bus.frame_err}, 32'd0);
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.uart_finish && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.uart_finish}, 32'd1);
  endtask

  // Monitor: every word_count advance pops one expected commit.
  logic [14:0] prev_wc;
  exp_t        mon_e;
  initial begin
    prev_wc = '0;
    forever begin
      @(negedge clk);
      if (bus.word_count > prev_wc) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_commit: word_count %0d with nothing expected", bus.word_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_data",  bus.uart_data, mon_e.data);
          check("commit_addr",  bus.uart_addr, mon_e.addr);
          check("commit_count", {17'd0, bus.word_count}, {17'd0, mon_e.wc});
          if (mon_e.fin_next) begin
            check("finish_low_at_cap_commit", {31'd0, bus.uart_finish}, 32'd0);
            @(negedge clk);
            check("finish_after_cap_commit", {31'd0, bus.uart_finish}, 32'd1);
          end
        end
      end
      prev_wc = bus.word_count;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    @(negedge clk);

    // Basic word, then idle timeout, then frozen.
    push(32'h12345678, 32'h0, 1, 1'b0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check("basic_no_early_finish", {31'd0, bus.uart_finish}, 32'd0);
    wait_finish("basic_timeout_finish", 400);
    check("basic_count", {17'd0, bus.word_count}, 32'd1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("basic_frozen_data", bus.uart_data, 32'h12345678);
    check("basic_frozen_count", {17'd0, bus.word_count}, 32'd1);

    // Three words hit MAX_WORDS; further bytes ignored.
    do_reset();
    push(32'h03020100, 32'h0, 1, 1'b0);
    push(32'h07060504, 32'h4, 2, 1'b0);
    push(32'h0B0A0908, 32'h8, 3, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(8'hAA, 1'b1);
    check("cap_count", {17'd0, bus.word_count}, 32'd3);
    check("cap_data", bus.uart_data, 32'h0B0A0908);
    check("cap_addr", bus.uart_addr, 32'h8);
    check("cap_finish", {31'd0, bus.uart_finish}, 32'd1);

    // Partial word is dropped on timeout.
    do_reset();
    push(32'hDDCCBBAA, 32'h0, 1, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("partial_count_pre", {17'd0, bus.word_count}, 32'd1);
    wait_finish("partial_timeout_finish", 400);
    check("partial_count", {17'd0, bus.word_count}, 32'd1);
    check("partial_data", bus.uart_data, 32'hDDCCBBAA);
    check("partial_addr", bus.uart_addr, 32'h0);

    // Framing error does not consume a byte slot.
    do_reset();
    send_byte(8'h55, 1'b0);
    check("ferr_set", {31'd0, bus.frame_err}, 32'd1);
    check("ferr_count", {17'd0, bus.word_count}, 32'd0);
    push(32'hDEADBEEF, 32'h0, 1, 1'b0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    repeat (2) @(negedge clk);
    check("ferr_sticky", {31'd0, bus.frame_err}, 32'd1);
    check("ferr_no_finish", {31'd0, bus.uart_finish}, 32'd0);

    // Skip one cycle after reset.
    do_reset();
    check("skip_finish_before", {31'd0, bus.uart_finish}, 32'd0);
    skip = 1'b1;
    repeat (2) @(negedge clk);
    check("skip_finish", {31'd0, bus.uart_finish}, 32'd1);
    check("skip_data", bus.uart_data, 32'h0);
    check("skip_count", {17'd0, bus.word_count}, 32'd0);
    send_byte(8'h5A, 1'b1);
    check("skip_ignores_rx", {17'd0, bus.word_count}, 32'd0);
    skip = 1'b0;

    // Reset mid-byte of the second word, then a one-cycle glitch.
    do_reset();
    push(32'h44332211, 32'h0, 1, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    rst = 1'b0;
    #1;
    check_reset("midbyte");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_count", {17'd0, bus.word_count}, 32'd0);
    push(32'hD4C3B2A1, 32'h0, 1, 1'b0);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    repeat (5) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
